astro_sprite_reader: RTL and testbench
======================================

// Module: astro_sprite_reader
// PURPOSE
//  Read-side client of the 20x20 astronaut sprite memory (sync read, 1-cycle latency, 5-bit data).
//  - Takes the VGA raster position (DrawX/DrawY) and the sprite's screen position.
//  - Generates the sprite-memory read address and absorbs the memory read latency.
//  - Emits a pipelined colour index plus a sprite_on flag to the colour mapper.
//  - Sprite position/enable are latched once per frame, so mid-frame moves never tear.
// PARAMETERS
//  SPRITE_W     20   sprite width, pixels
//  SPRITE_H     20   sprite height, pixels
//  BASE_ADDR    0    first memory word of the sprite image
//  ADDR_W       19   read_address width
//  DATA_W       5    colour-index width (matches memory data_Out)
//  COORD_W      10   DrawX/DrawY/position width
//  TRANSPARENT  0    colour index treated as "no sprite pixel"
// PORTS
//  Clk           in   1        system clock, all logic on posedge
//  Reset_n       in   1        asynchronous active-low reset
//  frame_start   in   1        1-cycle pulse at start of vertical blank
//  sprite_en     in   1        draw-enable, sampled on frame_start
//  SpriteX       in   COORD_W  sprite top-left X, sampled on frame_start
//  SpriteY       in   COORD_W  sprite top-left Y, sampled on frame_start
//  pix_valid     in   1        DrawX/DrawY are a visible pixel this cycle
//  DrawX, DrawY  in   COORD_W  raster coordinates
//  read_address  out  ADDR_W   to sprite memory read_address
//  mem_data      in   DATA_W   from sprite memory data_Out
//  out_valid     out  1        pix_valid delayed by 3 cycles
//  sprite_on     out  1        sprite covers this pixel and is opaque
//  color_idx     out  DATA_W   palette index; 0 when sprite_on=0
// BEHAVIOUR
//  - Reset (async, Reset_n=0):
//    - read_address=BASE_ADDR; out_valid, sprite_on, color_idx=0.
//    - Latched position=0; latched enable=0; FSM=WAIT_FRAME; all pipeline valids cleared.
//    - Asserting reset mid-frame discards in-flight pixels; no output is produced for them.
//  - FSM:
//    - WAIT_FRAME: out_valid follows pix_valid through the pipe, sprite_on forced 0.
//      -> ACTIVE on the first frame_start.
//    - ACTIVE: normal operation; stays ACTIVE until reset.
//  - frame_start latches SpriteX/SpriteY/sprite_en. The new values apply to pixels sampled
//    on the cycle AFTER the pulse; a pixel coincident with frame_start uses the old values.
//  - Stage 1 (edge k, pix_valid sampled):
//    - dx=DrawX-SpriteX, dy=DrawY-SpriteY, computed at COORD_W+1 bits.
//    - hit = sprite_en_l & DrawX>=SpriteX & DrawY>=SpriteY & dx<SPRITE_W & dy<SPRITE_H.
//      No wrap for sprites partly off-screen.
//    - read_address <= BASE_ADDR + dy*SPRITE_W + dx when hit; otherwise read_address holds.
//    - Valid and hit bits are registered alongside the address.
//  - Stage 2 (edge k+1): memory registers mem_data; the reader shifts valid/hit one stage.
//  - Stage 3 (edge k+2): registered outputs.
//    - out_valid = valid.
//    - sprite_on = valid & hit & (mem_data != TRANSPARENT).
//    - color_idx = sprite_on ? mem_data : 0.
//  - Latency: out_valid rises 3 edges after pix_valid is sampled. Full throughput: one pixel
//    per clock, no stalls, back-to-back pixels allowed.
//  - Address range: SPRITE_W*SPRITE_H-1+BASE_ADDR must fit in ADDR_W; dy*SPRITE_W is sized to ADDR_W.
// CONFIGURATION
//  ASTRO_SPRITE_FLIP_EN defined:
//    - Adds input facing_left (1 bit), latched on frame_start like sprite_en.
//    - When latched 1, the column used is SPRITE_W-1-dx (horizontal mirror). hit is unchanged.
//  ASTRO_SPRITE_FLIP_EN undefined: facing_left port absent; the column is always dx.
// TESTING
//  - Reset, no frame_start, pix_valid=1 at X=Y=0 with Sprite at 0,0: out_valid=1 after 3 cycles, sprite_on=0 (WAIT_FRAME).
//  - frame_start with Sprite=(100,50), en=1; DrawX=105,DrawY=52: read_address=45 one edge later; mem_data=7 -> color_idx=7, sprite_on=1 at edge +3.
//  - Same position, DrawX=120 (dx=20) or DrawX=99: no address update, sprite_on=0. mem_data=TRANSPARENT inside box -> sprite_on=0, color_idx=0.
//  - SpriteX=630, DrawX=639: hit, dx=9. DrawX=5 next line: no hit, no wrap.
//  - SpriteX changed mid-frame without frame_start: output unchanged. Pixel coincident with frame_start uses old position.
//  - Reset_n pulsed low with 3 pixels in flight: all outputs 0 immediately, no stale out_valid afterwards.
//  - FLIP_EN build: facing_left=1 latched, dx=0,dy=0 -> read_address=19.

Source files
------------

// File: rtl/astro_sprite_reader.sv
// Read-side client of the astronaut sprite ROM: raster position in, registered colour index out (3-cycle pipe).
// Optional horizontal mirroring is compiled in with ASTRO_SPRITE_FLIP_EN (adds the facing_left input).
module astro_sprite_reader #(
  parameter int SPRITE_W    = 20,
  parameter int SPRITE_H    = 20,
  parameter int BASE_ADDR   = 0,
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 5,
  parameter int COORD_W     = 10,
  parameter int TRANSPARENT = 0
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_start,
  input  logic               sprite_en,
  input  logic [COORD_W-1:0] SpriteX,
  input  logic [COORD_W-1:0] SpriteY,
`ifdef ASTRO_SPRITE_FLIP_EN
  input  logic               facing_left,
`endif
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  output logic [ADDR_W-1:0]  read_address,
  input  logic [DATA_W-1:0]  mem_data,
  output logic               out_valid,
  output logic               sprite_on,
  output logic [DATA_W-1:0]  color_idx
);

  typedef enum logic {WAIT_FRAME, ACTIVE} state_t;
  state_t state_q, state_d;

  logic               en_q;
  logic [COORD_W-1:0] sx_q, sy_q;
  logic               flip;
`ifdef ASTRO_SPRITE_FLIP_EN
  logic               flip_q;
  assign flip = flip_q;
`else
  assign flip = 1'b0;
`endif

  logic [COORD_W:0]  dx, dy, col;
  logic              hit_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              v1_q, h1_q, v2_q, h2_q;
  logic              out_valid_q, sprite_on_q, sprite_on_d;
  logic [DATA_W-1:0] color_q, color_d;

  always_comb begin
    state_d = state_q;
    if (state_q == WAIT_FRAME && frame_start) state_d = ACTIVE;
  end

  // The extra sign bit of dx/dy flags a raster position left of / above the sprite, so no wrap.
  always_comb begin
    dx    = {1'b0, DrawX} - {1'b0, sx_q};
    dy    = {1'b0, DrawY} - {1'b0, sy_q};
    hit_d = (state_q == ACTIVE) & en_q & ~dx[COORD_W] & ~dy[COORD_W]
          & (dx < (COORD_W+1)'(SPRITE_W)) & (dy < (COORD_W+1)'(SPRITE_H));
    col   = flip ? ((COORD_W+1)'(SPRITE_W - 1) - dx) : dx;
    addr_d = addr_q;
    if (hit_d)
      addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(dy) * ADDR_W'(SPRITE_W) + ADDR_W'(col);
  end

  always_comb begin
    sprite_on_d = v2_q & h2_q & (mem_data != DATA_W'(TRANSPARENT));
    color_d     = sprite_on_d ? mem_data : '0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= WAIT_FRAME;
      en_q        <= 1'b0;
      sx_q        <= '0;
      sy_q        <= '0;
      addr_q      <= ADDR_W'(BASE_ADDR);
      v1_q        <= 1'b0;
      h1_q        <= 1'b0;
      v2_q        <= 1'b0;
      h2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      sprite_on_q <= 1'b0;
      color_q     <= '0;
    end else begin
      state_q <= state_d;
      // Latched values take effect on the next pixel; this cycle's pixel used the old ones.
      if (frame_start) begin
        en_q <= sprite_en;
        sx_q <= SpriteX;
        sy_q <= SpriteY;
      end
      addr_q      <= addr_d;
      v1_q        <= pix_valid;
      h1_q        <= hit_d;
      v2_q        <= v1_q;
      h2_q        <= h1_q;
      out_valid_q <= v2_q;
      sprite_on_q <= sprite_on_d;
      color_q     <= color_d;
    end
  end

`ifdef ASTRO_SPRITE_FLIP_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)         flip_q <= 1'b0;
    else if (frame_start) flip_q <= facing_left;
  end
`endif

  assign read_address = addr_q;
  assign out_valid    = out_valid_q;
  assign sprite_on    = sprite_on_q;
  assign color_idx    = color_q;

endmodule

// File: tb/tb_astro_sprite_reader.sv
// Randomised bench for astro_sprite_reader against a per-pixel arithmetic model with a modelled sync ROM.
module tb_astro_sprite_reader;
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_start = 1'b0, sprite_en = 1'b0, pix_valid = 1'b0;
  logic [9:0]  SpriteX = '0, SpriteY = '0, DrawX = '0, DrawY = '0;
  logic        facing_left = 1'b0;
  logic [18:0] read_address;
  logic [4:0]  mem_data = '0;
  logic        out_valid, sprite_on;
  logic [4:0]  color_idx;

  logic [4:0]  mem [0:511];
  int n_checks = 0, n_pass = 0;

  // Model state: latched frame values, expected address, and expected outputs per pixel age.
  int m_sx, m_sy, m_en, m_fl, m_active, m_addr;
  int e_v [3], e_on [3], e_c [3];

  astro_sprite_reader dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .sprite_en(sprite_en),
    .SpriteX(SpriteX), .SpriteY(SpriteY),
`ifdef ASTRO_SPRITE_FLIP_EN
    .facing_left(facing_left),
`endif
    .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY), .read_address(read_address),
    .mem_data(mem_data), .out_valid(out_valid), .sprite_on(sprite_on), .color_idx(color_idx)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) mem_data <= mem[read_address[8:0]];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_clear();
    m_sx = 0; m_sy = 0; m_en = 0; m_fl = 0; m_active = 0; m_addr = 0;
    for (int i = 0; i < 3; i++) begin e_v[i] = 0; e_on[i] = 0; e_c[i] = 0; end
  endtask

  // Drive one cycle's inputs, predict, clock, then check one line per transaction.
  task automatic step(input bit fs, input bit en, input int sx, input int sy,
                      input bit pv, input int x, input int y, input bit fl);
    int hit, col, v, on, c;
    frame_start = fs; sprite_en = en; SpriteX = 10'(sx); SpriteY = 10'(sy);
    pix_valid = pv; DrawX = 10'(x); DrawY = 10'(y); facing_left = fl;
    x = x & 1023; y = y & 1023;
    hit = m_active && m_en && x >= m_sx && y >= m_sy && (x - m_sx) < 20 && (y - m_sy) < 20;
    col = m_fl ? 19 - (x - m_sx) : x - m_sx;
    if (hit) m_addr = (y - m_sy) * 20 + col;
    v  = pv;
    on = pv && hit && mem[m_addr] != 0;
    c  = on ? int'(mem[m_addr]) : 0;
    if (fs) begin
      m_sx = sx & 1023; m_sy = sy & 1023; m_en = en; m_active = 1;
`ifdef ASTRO_SPRITE_FLIP_EN
      m_fl = fl;
`endif
    end
    @(posedge Clk); #1;
    e_v[2] = e_v[1]; e_on[2] = e_on[1]; e_c[2] = e_c[1];
    e_v[1] = e_v[0]; e_on[1] = e_on[0]; e_c[1] = e_c[0];
    e_v[0] = v;      e_on[0] = on;      e_c[0] = c;
    $display("t=%0t fs=%0d pv=%0d xy=(%0d,%0d) addr=%0d ov=%0d on=%0d c=%0d",
             $time, fs, pv, x, y, read_address, out_valid, sprite_on, color_idx);
    check("read_address", int'(read_address), m_addr);
    check("out_valid", int'(out_valid), e_v[2]);
    check("sprite_on", int'(sprite_on), e_on[2]);
    check("color_idx", int'(color_idx), e_c[2]);
  endtask

  task automatic do_reset();
    #2 Reset_n = 1'b0;
    frame_start = 1'b0; pix_valid = 1'b0;
    #1;
    $display("t=%0t reset asserted", $time);
    check("rst_addr", int'(read_address), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_on", int'(sprite_on), 0);
    check("rst_color", int'(color_idx), 0);
    model_clear();
    repeat (2) @(posedge Clk);
    #3 Reset_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = (i % 5 == 0) ? 5'd0 : 5'($urandom);
    mem[45] = 5'd7;
    mem[46] = 5'd0;
    model_clear();
    @(posedge Clk); #1;
    do_reset();

    // No frame_start yet: pixels pass through with sprite_on held low.
    step(0, 1, 0, 0, 1, 0, 0, 0);
    idle(3);

    // Sprite at (100,50): inside, right edge, left edge, transparent.
    step(1, 1, 100, 50, 0, 0, 0, 0);
    step(0, 1, 100, 50, 1, 105, 52, 0);
    step(0, 1, 100, 50, 1, 120, 52, 0);
    step(0, 1, 100, 50, 1, 99, 52, 0);
    step(0, 1, 100, 50, 1, 106, 52, 0);
    step(0, 1, 300, 50, 1, 105, 52, 0);   // unlatched move ignored
    step(1, 1, 200, 50, 1, 105, 52, 0);   // coincident pixel uses old position
    step(0, 1, 200, 50, 1, 105, 52, 0);
    idle(3);

    // Sprite near the right screen edge: hit at 639, no wrap to column 5.
    step(1, 1, 630, 50, 0, 0, 0, 0);
    step(0, 1, 630, 50, 1, 639, 55, 0);
    step(0, 1, 630, 50, 1, 5, 56, 0);
    idle(3);

`ifdef ASTRO_SPRITE_FLIP_EN
    step(1, 1, 100, 50, 0, 0, 0, 1);
    step(0, 1, 100, 50, 1, 100, 50, 1);
    check("flip_addr19", int'(read_address), 19);
    idle(3);
`endif

    // Reset with three pixels in flight; nothing stale may emerge afterwards.
    step(1, 1, 100, 50, 1, 101, 51, 0);
    step(0, 1, 100, 50, 1, 102, 51, 0);
    step(0, 1, 100, 50, 1, 103, 51, 0);
    do_reset();
    idle(4);

    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0),
                $urandom_range(0, 639), $urandom_range(0, 479),
                ($urandom_range(0, 3) != 0),
                m_sx + $urandom_range(0, 25) - 3, m_sy + $urandom_range(0, 25) - 3,
                $urandom_range(0, 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
